counter_seq_ctrl: RTL

//  Command-driven sequencer that drives the control side of a W-bit loadable up/down counter.

---
 rtl/counter_pkg.sv | 19 +
 rtl/counter_seq_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared types for the counter sequencer: command modes, FSM states and the default width.
package counter_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_REPEAT = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10
    } state_t;

endpackage

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for a loadable up/down counter: one-shot, bounce and repeat sweeps.
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | one cycle: load latched start into the counter
// RUN   | counting toward target; halts on target, then turns, reloads or finishes
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int REPS_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [W-1:0]      cmd_start,
    input  logic [W-1:0]      cmd_stop,
    input  logic [REPS_W-1:0] cmd_reps,
    input  logic              abort,
    output logic [W-1:0]      data,
    output logic              load,
    output logic              enable,
    output logic              up_down,
    input  logic [W-1:0]      result,
    input  logic              terminal_count,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              wrap_err,
    output logic [REPS_W-1:0] pass_cnt
);

    state_t              state;
    mode_t               mode_q;
    logic [W-1:0]        stop_q;
    logic [W-1:0]        target_q;
    logic [REPS_W-1:0]   reps_q;

    logic                hit;
    logic [REPS_W:0]     pass_inc;
    logic                last_pass;
    logic [REPS_W-1:0]   pass_sat;

    always_comb begin
        hit       = (result == target_q);
        pass_inc  = (REPS_W+1)'(pass_cnt) + (REPS_W+1)'(1);
        last_pass = (pass_inc == (REPS_W+1)'(reps_q));
        pass_sat  = (pass_cnt == '1) ? pass_cnt : pass_inc[REPS_W-1:0];
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    // The counter stops by itself on target because enable drops in the same cycle.
    assign enable    = (state == LOAD) || ((state == RUN) && !hit);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            mode_q   <= MODE_UP;
            stop_q   <= '0;
            target_q <= '0;
            reps_q   <= '0;
            data     <= '0;
            load     <= 1'b0;
            up_down  <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            wrap_err <= 1'b0;
            pass_cnt <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            load    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        mode_q   <= mode_t'(cmd_mode);
                        data     <= cmd_start;
                        stop_q   <= cmd_stop;
                        target_q <= cmd_stop;
                        reps_q   <= (cmd_reps == '0) ? REPS_W'(1) : cmd_reps;
                        up_down  <= (mode_t'(cmd_mode) != MODE_DOWN);
                        pass_cnt <= '0;
                        wrap_err <= 1'b0;
                        load     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        if (up_down && terminal_count && !hit)
                            wrap_err <= 1'b1;
                        if (hit) begin
                            case (mode_q)
                                MODE_UP, MODE_DOWN: begin
                                    pass_cnt <= pass_sat;
                                    done     <= 1'b1;
                                    state    <= IDLE;
                                end
                                MODE_BOUNCE: begin
                                    if (up_down) begin
                                        up_down  <= 1'b0;
                                        target_q <= data;
                                    end else begin
                                        pass_cnt <= pass_sat;
                                        if (last_pass) begin
                                            done  <= 1'b1;
                                            state <= IDLE;
                                        end else begin
                                            up_down  <= 1'b1;
                                            target_q <= stop_q;
                                        end
                                    end
                                end
                                MODE_REPEAT: begin
                                    pass_cnt <= pass_sat;
                                    if (last_pass) begin
                                        done  <= 1'b1;
                                        state <= IDLE;
                                    end else begin
                                        load  <= 1'b1;
                                        state <= LOAD;
                                    end
                                end
                            endcase
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
